// File: rtl/alu_tx_pkg.sv
// Shared definitions for the ALU result serial transmitter.
// The frame-length constants cover both builds, with and without ALU_TX_PARITY_EN.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int unsigned DATA_BITS           = 8;
  localparam int unsigned FRAME_BITS_NOPARITY = 10;
  localparam int unsigned FRAME_BITS_PARITY   = 11;

  // Frame byte layout: flags in the upper nibble, ALU result in the lower nibble.
  function automatic logic [DATA_BITS-1:0] pack_frame(
    input logic [3:0] result,
    input logic       carry,
    input logic       overflow,
    input logic       zero,
    input logic       negative
  );
    return {negative, zero, overflow, carry, result};
  endfunction

endpackage

// File: rtl/alu_tx_baud.sv
// Baud counter for alu_result_tx: counts 0..CLKS_PER_BIT-1 and emits a
// bit_end tick on the last count. The counter restarts on clear.
module alu_tx_baud #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/alu_result_tx.sv
// UART-style transmitter for one ALU result frame: start, D[0..7], optional
// even parity (ALU_TX_PARITY_EN), stop. Every output is registered.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] result,
  input  logic       carry,
  input  logic       overflow,
  input  logic       zero,
  input  logic       negative,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [2:0]           bit_idx, bit_idx_next, bit_idx_inc;
  logic                 tx_next, busy_next, done_next;
  logic                 bit_end, baud_clear;

  // Any state change restarts the bit timing.
  assign baud_clear = (state_next != state);

  alu_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  assign bit_idx_inc = bit_idx + 3'd1;

  // tx/busy/done are computed from the next state so they update on the
  // same edge as the state register.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    tx_next      = tx;
    busy_next    = busy;
    done_next    = 1'b0;
    case (state)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          state_next = S_START;
          shreg_next = pack_frame(result, carry, overflow, zero, negative);
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          tx_next    = shreg[bit_idx];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_idx_next = bit_idx_inc;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef ALU_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = ^shreg;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            tx_next = shreg[bit_idx_inc];
          end
        end
      end
`ifdef ALU_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_next = S_IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

endmodule
